// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and packer state encoding for the nibble FIFO family.
package fifo_pkg;
   localparam int NIB_W_DEF  = 4;
   localparam int FIFO_DEPTH = 8;
   typedef enum logic {FILL, OUT} pack_state_t;
endpackage

// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer: drains a 1-cycle-latency nibble FIFO and packs NIBS nibbles per valid/ready word.
// Optional PACK_WORD_COUNT_EN adds word_cnt, a 16-bit count of completed handshakes.
module fifo_nibble_packer
   import fifo_pkg::*;
#(
   parameter int NIB_W = NIB_W_DEF,
   parameter int NIBS  = 2,
   parameter int CNT_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [NIB_W-1:0]      fifo_rd_data,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [NIB_W*NIBS-1:0] m_data,
`ifdef PACK_WORD_COUNT_EN
   output logic [15:0]           word_cnt,
`endif
   output logic                  m_partial
);
   localparam int W = NIB_W * NIBS;
   localparam logic [CNT_W:0] NIBS_C = (CNT_W + 1)'(NIBS);
   pack_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_pend_q, flush_req_q, flush_req_d;
   logic [W-1:0]     acc_q, acc_d, m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d, m_partial_q, m_partial_d;
   // Count in-flight reads so the word never overfills.
   assign fifo_rd_en = (state_q == FILL) && !fifo_empty && !flush_req_q &&
                       (({1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_pend_q}) < NIBS_C);
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      flush_req_d = flush_req_q | (flush && state_q == FILL);
      acc_d       = acc_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_partial_d = m_partial_q;
      if (state_q == OUT) begin
         if (m_ready) begin
            state_d   = FILL;
            cnt_d     = '0;
            acc_d     = '0;
            m_valid_d = 1'b0;
         end
      end else if (rd_pend_q) begin
         for (int i = 0; i < NIBS; i++)
            if (cnt_q == CNT_W'(i)) acc_d[i*NIB_W +: NIB_W] = fifo_rd_data;
         cnt_d = cnt_q + CNT_W'(1);
         if ({1'b0, cnt_d} == NIBS_C) begin
            state_d     = OUT;
            m_valid_d   = 1'b1;
            m_partial_d = 1'b0;
            m_data_d    = acc_d;
            flush_req_d = 1'b0;
         end
      end else if (flush_req_q) begin
         // Pending read has landed; close whatever has been collected.
         flush_req_d = 1'b0;
         if (cnt_q != '0) begin
            state_d     = OUT;
            m_valid_d   = 1'b1;
            m_partial_d = 1'b1;
            m_data_d    = acc_q;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         rd_pend_q   <= 1'b0;
         flush_req_q <= 1'b0;
         acc_q       <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_partial_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_pend_q   <= fifo_rd_en;
         flush_req_q <= flush_req_d;
         acc_q       <= acc_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_partial_q <= m_partial_d;
      end
   end
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_partial = m_partial_q;
`ifdef PACK_WORD_COUNT_EN
   logic [15:0] word_cnt_q;
   always_ff @(posedge clk) begin
      if (rst) word_cnt_q <= '0;
      else if (m_valid_q && m_ready) word_cnt_q <= word_cnt_q + 16'd1;
   end
   assign word_cnt = word_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_nibble_packer.sv
// tb_fifo_nibble_packer: packer driven by a behavioural 8-deep registered-read FIFO, checked against
// nibble-stream expectations; covers the PACK_WORD_COUNT_EN counter when that macro is defined.
module tb_fifo_nibble_packer;
   import fifo_pkg::*;
   localparam int NIBS = 2;
   localparam int W    = NIB_W_DEF * NIBS;
   logic clk = 1'b0, rst = 1'b1, fifo_empty = 1'b1, fifo_rd_en, flush = 1'b0;
   logic m_valid, m_ready = 1'b0, m_partial, wr_en = 1'b0;
   logic [NIB_W_DEF-1:0] fifo_rd_data = '0, wr_data = '0;
   logic [W-1:0] m_data;
`ifdef PACK_WORD_COUNT_EN
   logic [15:0] word_cnt;
`endif
   int checks = 0, passes = 0;
   fifo_nibble_packer #(.NIB_W(NIB_W_DEF), .NIBS(NIBS), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data),
`ifdef PACK_WORD_COUNT_EN
      .word_cnt(word_cnt),
`endif
      .m_partial(m_partial)
   );
   always #5 clk = ~clk;
   // FIFO model: registered read data, empty flag updated after each edge.
   logic [NIB_W_DEF-1:0] fq[$];
   always @(posedge clk) begin
      if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (wr_en && fq.size() < FIFO_DEPTH) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
   end
   // Monitor sampling mid-cycle: handshakes, reads, and protocol violations.
   int cyc = 0, rd_cnt = 0, last_rd = -10, rd_b2b = 0, valid_cnt = 0, rise_cyc = 0;
   int prot_err = 0, hold_err = 0;
   logic prev_valid = 1'b0, hold_pend = 1'b0, hold_part = 1'b0;
   logic [W-1:0] hold_data = '0;
   logic [W-1:0] got_d[$];
   logic got_p[$];
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         hold_pend  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (fifo_rd_en) begin
            rd_cnt++;
            if (cyc == last_rd + 1) rd_b2b++;
            last_rd = cyc;
            if (fifo_empty || m_valid) prot_err++;
         end
         if (m_valid) valid_cnt++;
         if (m_valid && !prev_valid) rise_cyc = cyc;
         if (hold_pend && !(m_valid && m_data == hold_data && m_partial == hold_part)) hold_err++;
         hold_pend  = m_valid && !m_ready;
         hold_data  = m_data;
         hold_part  = m_partial;
         prev_valid = m_valid;
         if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_p.push_back(m_partial);
         end
      end
   end
   function automatic logic [W-1:0] word_at(int i);
      return (i < got_d.size()) ? got_d[i] : 'x;
   endfunction
   function automatic logic part_at(int i);
      return (i < got_p.size()) ? got_p[i] : 1'bx;
   endfunction
   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic push(logic [NIB_W_DEF-1:0] v);
      wr_en   = 1'b1;
      wr_data = v;
      tick();
      wr_en   = 1'b0;
   endtask
   task automatic wait_words(int n, int budget);
      int k = 0;
      while (got_d.size() < n && k < budget) begin
         tick();
         k++;
      end
   endtask
   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      @(negedge clk);
      checks++;
      if ({m_valid, m_partial, m_data} !== '0) $display("FAIL reset_outputs: got %h want 0", {m_valid, m_partial, m_data});
      else passes++;
      checks++;
      if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en);
      else passes++;
      rst = 1'b0;
      tick();
   endtask
   task automatic test_basic();
      int b, r0, v0, bb0;
      b = got_d.size(); r0 = rd_cnt; v0 = valid_cnt; bb0 = rd_b2b;
      m_ready = 1'b1;
      push(4'hA);
      push(4'hB);
      wait_words(b + 1, 20);
      tick(3);
      checks++;
      if (word_at(b) !== 8'hBA) $display("FAIL basic_word: got %h want ba", word_at(b));
      else passes++;
      checks++;
      if (part_at(b) !== 1'b0) $display("FAIL basic_partial: got %b want 0", part_at(b));
      else passes++;
      checks++;
      if (rd_cnt - r0 != 2 || rd_b2b - bb0 != 1) $display("FAIL basic_reads: got %0d reads %0d b2b want 2/1", rd_cnt - r0, rd_b2b - bb0);
      else passes++;
      checks++;
      if (rise_cyc - last_rd != 2) $display("FAIL basic_latency: got %0d want 2", rise_cyc - last_rd);
      else passes++;
      checks++;
      if (valid_cnt - v0 != 1) $display("FAIL basic_valid_cycles: got %0d want 1", valid_cnt - v0);
      else passes++;
   endtask
   task automatic test_hold();
      int b, r0, r1, h0, p0, k;
      b = got_d.size(); r0 = rd_cnt; h0 = hold_err; p0 = prot_err; k = 0;
      m_ready = 1'b0;
      for (int i = 1; i <= 6; i++) push(4'(i));
      while (!m_valid && k < 20) begin
         tick();
         k++;
      end
      r1 = rd_cnt;
      tick(5);
      checks++;
      if (r1 - r0 != 2 || rd_cnt != r1) $display("FAIL hold_reads: got %0d then %0d want 2 then 0", r1 - r0, rd_cnt - r1);
      else passes++;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h21 || got_d.size() != b) $display("FAIL hold_word: got v=%b d=%h want v=1 d=21", m_valid, m_data);
      else passes++;
      m_ready = 1'b1;
      wait_words(b + 3, 40);
      checks++;
      if ({word_at(b), word_at(b + 1), word_at(b + 2)} !== 24'h214365) $display("FAIL hold_order: got %h %h %h want 21 43 65", word_at(b), word_at(b + 1), word_at(b + 2));
      else passes++;
      checks++;
      if (hold_err != h0 || prot_err != p0) $display("FAIL hold_protocol: got hold_err %0d prot_err %0d want 0", hold_err - h0, prot_err - p0);
      else passes++;
   endtask
   task automatic test_empty_gap();
      int b, r0, v0;
      b = got_d.size(); r0 = rd_cnt; v0 = valid_cnt;
      tick(10);
      checks++;
      if (rd_cnt != r0 || valid_cnt != v0) $display("FAIL empty_idle: got %0d reads %0d valid want 0", rd_cnt - r0, valid_cnt - v0);
      else passes++;
      push(4'h3);
      tick(4);
      push(4'h7);
      wait_words(b + 1, 20);
      checks++;
      if (word_at(b) !== 8'h73 || part_at(b) !== 1'b0) $display("FAIL empty_gap_word: got %h p=%b want 73 p=0", word_at(b), part_at(b));
      else passes++;
   endtask
   task automatic test_flush();
      int b, v0;
      b = got_d.size();
      push(4'h5);
      tick(4);
      pulse_flush();
      wait_words(b + 1, 20);
      checks++;
      if (word_at(b) !== 8'h05 || part_at(b) !== 1'b1) $display("FAIL flush_partial: got %h p=%b want 05 p=1", word_at(b), part_at(b));
      else passes++;
      tick(2);
      v0 = valid_cnt;
      pulse_flush();
      tick(8);
      checks++;
      if (valid_cnt != v0) $display("FAIL flush_empty: got %0d valid cycles want 0", valid_cnt - v0);
      else passes++;
      push(4'h2);
      push(4'h4);
      wait_words(b + 2, 20);
      checks++;
      if (word_at(b + 1) !== 8'h42 || part_at(b + 1) !== 1'b0) $display("FAIL flush_after: got %h p=%b want 42 p=0", word_at(b + 1), part_at(b + 1));
      else passes++;
   endtask
   task automatic test_flush_pending();
      int b, r0;
      b = got_d.size(); r0 = rd_cnt;
      wr_en   = 1'b1;
      wr_data = 4'h9;
      tick();
      wr_data = 4'hC;
      flush   = 1'b1;
      tick();
      wr_en = 1'b0;
      flush = 1'b0;
      wait_words(b + 1, 20);
      checks++;
      if (word_at(b) !== 8'h09 || part_at(b) !== 1'b1) $display("FAIL pend_word: got %h p=%b want 09 p=1", word_at(b), part_at(b));
      else passes++;
      checks++;
      if (fq.size() != 1 || rd_cnt - r0 != 1) $display("FAIL pend_left: got fifo %0d reads %0d want 1/1", fq.size(), rd_cnt - r0);
      else passes++;
      tick(3);
      pulse_flush();
      wait_words(b + 2, 20);
      checks++;
      if (word_at(b + 1) !== 8'h0C || part_at(b + 1) !== 1'b1) $display("FAIL pend_drain: got %h p=%b want 0c p=1", word_at(b + 1), part_at(b + 1));
      else passes++;
   endtask
   task automatic test_reset_mid();
      int b;
      push(4'h1);
      tick(4);
      rst = 1'b1;
      tick();
      checks++;
      if ({m_valid, m_partial, m_data} !== '0) $display("FAIL midreset_outputs: got %h want 0", {m_valid, m_partial, m_data});
      else passes++;
      rst = 1'b0;
      b = got_d.size();
      tick(6);
      checks++;
      if (got_d.size() != b || m_valid !== 1'b0) $display("FAIL midreset_silent: got %0d words want 0", got_d.size() - b);
      else passes++;
      push(4'hE);
      push(4'hF);
      wait_words(b + 1, 20);
      tick();
      checks++;
      if (word_at(b) !== 8'hFE || part_at(b) !== 1'b0) $display("FAIL midreset_word: got %h p=%b want fe p=0", word_at(b), part_at(b));
      else passes++;
`ifdef PACK_WORD_COUNT_EN
      checks++;
      if (word_cnt !== 16'd1) $display("FAIL word_cnt_after_reset: got %0d want 1", word_cnt);
      else passes++;
`endif
   endtask
   task automatic test_random();
      logic [NIB_W_DEF-1:0] exp_q[$];
      logic [W-1:0] exp_w;
      int b, h0, p0, pushed, k;
`ifdef PACK_WORD_COUNT_EN
      logic [15:0] wc0;
      wc0 = word_cnt;
`endif
      b = got_d.size(); h0 = hold_err; p0 = prot_err; pushed = 0; k = 0;
      while (pushed < 40 && k < 2000) begin
         m_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0 && fq.size() < FIFO_DEPTH) begin
            wr_en   = 1'b1;
            wr_data = 4'($urandom_range(0, 15));
            exp_q.push_back(wr_data);
            pushed++;
         end else wr_en = 1'b0;
         tick();
         k++;
      end
      wr_en   = 1'b0;
      m_ready = 1'b1;
      wait_words(b + 20, 200);
      for (int i = 0; i < 20; i++) begin
         exp_w = '0;
         for (int j = 0; j < NIBS; j++) exp_w = exp_w | (W'(exp_q[i*NIBS + j]) << (NIB_W_DEF * j));
         checks++;
         if (word_at(b + i) !== exp_w || part_at(b + i) !== 1'b0) $display("FAIL rand_word%0d: got %h p=%b want %h p=0", i, word_at(b + i), part_at(b + i), exp_w);
         else passes++;
      end
      checks++;
      if (hold_err != h0 || prot_err != p0 || got_d.size() != b + 20) $display("FAIL rand_protocol: got hold %0d prot %0d words %0d want 0/0/20", hold_err - h0, prot_err - p0, got_d.size() - b);
      else passes++;
`ifdef PACK_WORD_COUNT_EN
      checks++;
      if (16'(word_cnt - wc0) !== 16'd20) $display("FAIL rand_word_cnt: got %0d want 20", 16'(word_cnt - wc0));
      else passes++;
`endif
   endtask
   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_empty_gap();
      test_flush();
      test_flush_pending();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
